rx_cmd_parser: RTL

RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

---
 rtl/rx_cmd_pkg.sv | 29 ++
 rtl/rx_cmd_timeout.sv | 28 ++
 rtl/rx_cmd_parser.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rx_cmd_pkg.sv
// Shared definitions for rx_cmd_parser: frame opcodes, command-type codes
// and the parser FSM state encoding.
package rx_cmd_pkg;
    localparam logic [7:0] OP_WRITE   = 8'hAA;
    localparam logic [7:0] OP_READ    = 8'hBB;
    localparam logic [7:0] OP_ALU_OPS = 8'hCC;
    localparam logic [7:0] OP_ALU_FUN = 8'hDD;

    localparam logic [1:0] CT_WRITE     = 2'b00;
    localparam logic [1:0] CT_READ      = 2'b01;
    localparam logic [1:0] CT_ALU_OPS   = 2'b10;
    localparam logic [1:0] CT_ALU_NOOPS = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        ALU_A,
        ALU_B,
        ALU_FUN,
        ISSUE
    } state_e;

    // True while a frame is partially received.
    function automatic logic is_mid_frame(input state_e s);
        return (s != IDLE) && (s != ISSUE);
    endfunction
endpackage

// File: rtl/rx_cmd_timeout.sv
// Inter-byte timeout: down-counter reloaded on every received byte, flags expiry
// once TIMEOUT_CYCLES byte-free cycles have elapsed while a frame is in progress.
module rx_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_active,
    output logic o_expired
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= RELOAD;
        end else if (i_clear || !i_active || (r_count == '0)) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = i_active && !i_clear && (r_count == '0);
endmodule

// File: rtl/rx_cmd_parser.sv
// Byte-stream command parser: assembles write/read/ALU frames from a UART receiver
// into a held command. Define RX_CMD_TIMEOUT_EN to abort frames stalled mid-way.
module rx_cmd_parser
    import rx_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] Rx_Data,
    input  logic                  Rx_valid,
    input  logic                  Rx_error,
    input  logic                  Cmd_ready,
    output logic                  Cmd_valid,
    output logic [1:0]            Cmd_type,
    output logic [ADDR_WIDTH-1:0] Cmd_addr,
    output logic [DATA_WIDTH-1:0] Cmd_data,
    output logic [DATA_WIDTH-1:0] Cmd_opA,
    output logic [DATA_WIDTH-1:0] Cmd_opB,
    output logic [3:0]            Cmd_fun,
    output logic                  Cmd_error,
    output logic                  Overrun
);
    // state   | meaning
    // IDLE    | waiting for an opcode byte
    // WR_ADDR | write frame, expecting address
    // WR_DATA | write frame, expecting data
    // RD_ADDR | read frame, expecting address
    // ALU_A   | ALU frame, expecting operand A
    // ALU_B   | ALU frame, expecting operand B
    // ALU_FUN | ALU frame, expecting function byte
    // ISSUE   | command presented, waiting for Cmd_ready

    state_e                r_state, w_state_nxt;
    logic                  w_err_evt, w_ovr_evt, w_advance, w_addr_bad, w_timeout;
    logic                  r_alu_ops, r_cmd_error, r_overrun;
    logic [1:0]            r_cmd_type;
    logic [ADDR_WIDTH-1:0] r_cmd_addr, r_addr_sh;
    logic [DATA_WIDTH-1:0] r_cmd_data, r_cmd_opa, r_cmd_opb, r_opa_sh, r_opb_sh;
    logic [3:0]            r_cmd_fun;

    assign w_addr_bad = ((Rx_Data >> ADDR_WIDTH) != '0);

`ifdef RX_CMD_TIMEOUT_EN
    rx_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (CLK),
        .i_reset  (Reset),
        .i_clear  (Rx_valid),
        .i_active (is_mid_frame(r_state)),
        .o_expired(w_timeout)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_evt   = 1'b0;
        w_ovr_evt   = 1'b0;
        w_advance   = 1'b0;
        if (r_state == ISSUE) begin
            w_ovr_evt = Rx_valid;
            if (Cmd_ready) begin
                w_state_nxt = IDLE;
            end
        end else if (w_timeout) begin
            w_state_nxt = IDLE;
            w_err_evt   = 1'b1;
        end else if (Rx_valid && Rx_error) begin
            w_state_nxt = IDLE;
            w_err_evt   = 1'b1;
        end else if (Rx_valid) begin
            w_advance = 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (Rx_Data == DATA_WIDTH'(OP_WRITE)) begin
                        w_state_nxt = WR_ADDR;
                    end else if (Rx_Data == DATA_WIDTH'(OP_READ)) begin
                        w_state_nxt = RD_ADDR;
                    end else if (Rx_Data == DATA_WIDTH'(OP_ALU_OPS)) begin
                        w_state_nxt = ALU_A;
                    end else if (Rx_Data == DATA_WIDTH'(OP_ALU_FUN)) begin
                        w_state_nxt = ALU_FUN;
                    end else begin
                        w_advance = 1'b0;
                        w_err_evt = 1'b1;
                    end
                end
                WR_ADDR, RD_ADDR: begin
                    if (w_addr_bad) begin
                        w_advance   = 1'b0;
                        w_err_evt   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = (r_state == WR_ADDR) ? WR_DATA : ISSUE;
                    end
                end
                WR_DATA: w_state_nxt = ISSUE;
                ALU_A:   w_state_nxt = ALU_B;
                ALU_B:   w_state_nxt = ALU_FUN;
                ALU_FUN: w_state_nxt = ISSUE;
                default: begin
                    w_advance   = 1'b0;
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Intermediate bytes go to shadow registers so an aborted frame never
    // disturbs the visible payload; fields commit on the final byte only.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_cmd_type  <= '0;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
            r_cmd_opa   <= '0;
            r_cmd_opb   <= '0;
            r_cmd_fun   <= '0;
            r_addr_sh   <= '0;
            r_opa_sh    <= '0;
            r_opb_sh    <= '0;
            r_alu_ops   <= 1'b0;
            r_cmd_error <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cmd_error <= w_err_evt;
            r_overrun   <= w_ovr_evt;
            if (w_advance) begin
                case (r_state)
                    IDLE:    r_alu_ops <= (Rx_Data == DATA_WIDTH'(OP_ALU_OPS));
                    WR_ADDR: r_addr_sh <= Rx_Data[ADDR_WIDTH-1:0];
                    WR_DATA: begin
                        r_cmd_type <= CT_WRITE;
                        r_cmd_addr <= r_addr_sh;
                        r_cmd_data <= Rx_Data;
                    end
                    RD_ADDR: begin
                        r_cmd_type <= CT_READ;
                        r_cmd_addr <= Rx_Data[ADDR_WIDTH-1:0];
                    end
                    ALU_A:   r_opa_sh <= Rx_Data;
                    ALU_B:   r_opb_sh <= Rx_Data;
                    ALU_FUN: begin
                        r_cmd_fun <= Rx_Data[3:0];
                        if (r_alu_ops) begin
                            r_cmd_type <= CT_ALU_OPS;
                            r_cmd_opa  <= r_opa_sh;
                            r_cmd_opb  <= r_opb_sh;
                        end else begin
                            r_cmd_type <= CT_ALU_NOOPS;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        Cmd_valid = (r_state == ISSUE);
        Cmd_type  = r_cmd_type;
        Cmd_addr  = r_cmd_addr;
        Cmd_data  = r_cmd_data;
        Cmd_opA   = r_cmd_opa;
        Cmd_opB   = r_cmd_opb;
        Cmd_fun   = r_cmd_fun;
        Cmd_error = r_cmd_error;
        Overrun   = r_overrun;
    end
endmodule
